ptp_pps_gen: RTL and testbench



---
 rtl/ptp_pps_gen.sv | 144 ++++++++++++++
 tb/tb_ptp_pps_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_pps_gen.sv
// ptp_pps_gen: pulse-per-second generator aligned to natural seconds
// rollovers, plus a one-shot target-time trigger, all in rtc_clk domain.
module ptp_pps_gen #(
    parameter logic [31:0] NS_MAX     = 32'd999_999_999,
    parameter logic [31:0] PW_DEFAULT = 32'd500_000_000
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst_n,
    input  logic [79:0] rtc_std_i,
    input  logic        pps_en_i,
    input  logic [31:0] pulse_width_i,
    input  logic [79:0] target_time_i,
    input  logic        target_arm_i,
    input  logic        target_cancel_i,
    output logic        pps_o,
    output logic [47:0] pps_sec_o,
    output logic [31:0] pps_cnt_o,
    output logic        target_pend_o,
    output logic        target_hit_o,
    output logic        target_err_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } trg_st_t;

    logic [79:0] r_cur;
    logic [47:0] r_prv_sec;
    logic [1:0]  r_vld;
    logic        r_pps;
    logic [47:0] r_pps_sec;
    logic [31:0] r_pps_cnt;
    trg_st_t     r_st;
    logic [79:0] r_tgt;
    logic        r_hit;
    logic        r_err;

    logic [47:0] w_cur_sec;
    logic [31:0] w_cur_ns;
    logic [31:0] w_pw_eff;
    logic        w_roll;
    logic        w_start;
    logic        w_end;
    logic        w_arm_bad;
    trg_st_t     w_st_nxt;
    logic [79:0] w_tgt_nxt;
    logic        w_hit_nxt;
    logic        w_err_nxt;

    assign w_cur_sec = r_cur[79:32];
    assign w_cur_ns  = r_cur[31:0];

    assign w_pw_eff = ((pulse_width_i == 32'd0) || (pulse_width_i > NS_MAX))
                    ? PW_DEFAULT : pulse_width_i;

    // r_vld[1] means prv holds a real sample, not the reset value
    assign w_roll  = r_vld[1] && (w_cur_sec == r_prv_sec + 48'd1);
    assign w_start = pps_en_i && w_roll;
    assign w_end   = (w_cur_ns >= w_pw_eff) || (w_cur_sec != r_pps_sec) ||
                     !pps_en_i;

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            r_cur     <= '0;
            r_prv_sec <= '0;
            r_vld     <= '0;
        end else begin
            r_cur     <= rtc_std_i;
            r_prv_sec <= w_cur_sec;
            r_vld     <= {r_vld[0], 1'b1};
        end
    end

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            r_pps     <= 1'b0;
            r_pps_sec <= '0;
            r_pps_cnt <= '0;
        end else if (w_start) begin
            r_pps     <= 1'b1;
            r_pps_sec <= w_cur_sec;
            r_pps_cnt <= r_pps_cnt + 32'd1;
        end else if (r_pps && w_end) begin
            r_pps     <= 1'b0;
        end
    end

    assign w_arm_bad = (target_time_i[31:0] > NS_MAX) ||
                       (target_time_i <= r_cur);

    always_comb begin
        w_st_nxt  = r_st;
        w_tgt_nxt = r_tgt;
        w_hit_nxt = 1'b0;
        w_err_nxt = 1'b0;
        case (r_st)
            S_IDLE: begin
                if (target_arm_i) begin
                    w_tgt_nxt = target_time_i;
                    if (w_arm_bad) w_err_nxt = 1'b1;
                    else           w_st_nxt  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (target_cancel_i) begin
                    w_st_nxt = S_IDLE;
                end else if (target_arm_i) begin
                    w_tgt_nxt = target_time_i;
                    if (w_arm_bad) begin
                        w_err_nxt = 1'b1;
                        w_st_nxt  = S_IDLE;
                    end
                end else if (r_cur >= r_tgt) begin
                    w_hit_nxt = 1'b1;
                    w_st_nxt  = S_IDLE;
                end
            end
            default: w_st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            r_st  <= S_IDLE;
            r_tgt <= '0;
            r_hit <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_st  <= w_st_nxt;
            r_tgt <= w_tgt_nxt;
            r_hit <= w_hit_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign pps_o         = r_pps;
    assign pps_sec_o     = r_pps_sec;
    assign pps_cnt_o     = r_pps_cnt;
    assign target_pend_o = (r_st == S_ARMED);
    assign target_hit_o  = r_hit;
    assign target_err_o  = r_err;

endmodule

// File: tb/tb_ptp_pps_gen.sv
// Scoreboard bench for ptp_pps_gen: a reference model pushes expected
// output events, a monitor pops and compares them as the DUT emits them.
module tb_ptp_pps_gen;

    localparam logic [31:0] NS_MAX = 32'd999_999_999;
    localparam logic [31:0] PW_DEF = 32'd500_000_000;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_HIT  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        int          at;
        logic [63:0] val;
    } ev_t;

    logic        rtc_clk = 1'b0;
    logic        rtc_rst_n;
    logic [79:0] rtc_std_i;
    logic        pps_en_i;
    logic [31:0] pulse_width_i;
    logic [79:0] target_time_i;
    logic        target_arm_i;
    logic        target_cancel_i;
    logic        pps_o;
    logic [47:0] pps_sec_o;
    logic [31:0] pps_cnt_o;
    logic        target_pend_o;
    logic        target_hit_o;
    logic        target_err_o;

    ptp_pps_gen dut (
        .rtc_clk         (rtc_clk),
        .rtc_rst_n       (rtc_rst_n),
        .rtc_std_i       (rtc_std_i),
        .pps_en_i        (pps_en_i),
        .pulse_width_i   (pulse_width_i),
        .target_time_i   (target_time_i),
        .target_arm_i    (target_arm_i),
        .target_cancel_i (target_cancel_i),
        .pps_o           (pps_o),
        .pps_sec_o       (pps_sec_o),
        .pps_cnt_o       (pps_cnt_o),
        .target_pend_o   (target_pend_o),
        .target_hit_o    (target_hit_o),
        .target_err_o    (target_err_o)
    );

    always #5 rtc_clk = ~rtc_clk;

    int  n_chk = 0;
    int  n_err = 0;
    int  edge_n = 0;
    int  n_hit = 0;
    int  n_errev = 0;
    int  r_edge = 0;
    int  f_edge = 0;
    ev_t q[$];

    // reference model state
    logic [79:0] m_cur;
    logic [79:0] m_prv;
    int          m_ns;
    logic        m_pps;
    logic [47:0] m_psec;
    logic [31:0] m_cnt;
    logic        m_arm;
    logic [79:0] m_tgt;

    logic        o_pps;
    logic [31:0] o_cnt;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h (edge %0d)",
                     tag, obs, exp, edge_n);
        end
    endtask

    task automatic got(input int kind, input logic [63:0] v);
        ev_t e;
        if (q.size() == 0) begin
            check("spurious_event", kind, 99);
        end else begin
            e = q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_edge", edge_n, e.at);
            check("ev_val", v, e.val);
        end
    endtask

    always @(posedge rtc_clk) begin
        edge_n++;
        #1;
        if (!rtc_rst_n) begin
            o_pps = 1'b0;
            o_cnt = '0;
        end else begin
            if (pps_cnt_o != o_cnt) begin
                r_edge = edge_n;
                got(K_RISE, {pps_cnt_o[15:0], pps_sec_o});
            end
            if (o_pps && !pps_o) begin
                f_edge = edge_n;
                got(K_FALL, 64'd0);
            end
            if (target_hit_o) begin
                n_hit++;
                got(K_HIT, 64'd0);
            end
            if (target_err_o) begin
                n_errev++;
                got(K_ERR, 64'd0);
            end
            o_pps = pps_o;
            o_cnt = pps_cnt_o;
        end
    end

    task automatic model_reset();
        m_cur  = '0;
        m_prv  = '0;
        m_ns   = 0;
        m_pps  = 1'b0;
        m_psec = '0;
        m_cnt  = '0;
        m_arm  = 1'b0;
        m_tgt  = '0;
    endtask

    // Present one time sample; the edge that captures it also acts on the
    // previously captured sample, which is what the model evaluates here.
    task automatic drive(input logic [47:0] s, input logic [31:0] n);
        int          k;
        logic [47:0] cs;
        logic [31:0] cn;
        logic [47:0] ps;
        logic [31:0] pe;
        logic        bad;
        k  = edge_n + 1;
        cs = m_cur[79:32];
        cn = m_cur[31:0];
        ps = m_prv[79:32];
        pe = (pulse_width_i == 0 || pulse_width_i > NS_MAX)
           ? PW_DEF : pulse_width_i;
        if (pps_en_i && m_ns >= 2 && cs == ps + 48'd1) begin
            m_cnt++;
            m_pps  = 1'b1;
            m_psec = cs;
            q.push_back('{K_RISE, k, {m_cnt[15:0], cs}});
        end else if (m_pps && (cn >= pe || cs != m_psec || !pps_en_i)) begin
            m_pps = 1'b0;
            q.push_back('{K_FALL, k, 64'd0});
        end
        bad = (target_time_i[31:0] > NS_MAX) || (target_time_i <= m_cur);
        if (!m_arm) begin
            if (target_arm_i) begin
                m_tgt = target_time_i;
                if (bad) q.push_back('{K_ERR, k, 64'd0});
                else     m_arm = 1'b1;
            end
        end else if (target_cancel_i) begin
            m_arm = 1'b0;
        end else if (target_arm_i) begin
            m_tgt = target_time_i;
            if (bad) begin
                q.push_back('{K_ERR, k, 64'd0});
                m_arm = 1'b0;
            end
        end else if (m_cur >= m_tgt) begin
            q.push_back('{K_HIT, k, 64'd0});
            m_arm = 1'b0;
        end
        m_prv = m_cur;
        m_cur = {s, n};
        if (m_ns < 2) m_ns++;
        rtc_std_i = {s, n};
        @(posedge rtc_clk);
        #2;
        target_arm_i    = 1'b0;
        target_cancel_i = 1'b0;
        check("pend", target_pend_o, m_arm);
        check("pps", pps_o, m_pps);
    endtask

    task automatic arm(input logic [47:0] s, input logic [31:0] n);
        target_time_i = {s, n};
        target_arm_i  = 1'b1;
    endtask

    initial begin
        rtc_rst_n       = 1'b0;
        rtc_std_i       = '0;
        pps_en_i        = 1'b1;
        pulse_width_i   = 32'd100;
        target_time_i   = '0;
        target_arm_i    = 1'b0;
        target_cancel_i = 1'b0;
        o_pps           = 1'b0;
        o_cnt           = '0;
        model_reset();
        repeat (2) @(posedge rtc_clk);
        #2;
        check("rst_pps", pps_o, 0);
        check("rst_sec", pps_sec_o, 0);
        check("rst_cnt", pps_cnt_o, 0);
        check("rst_pend", target_pend_o, 0);
        check("rst_hit", target_hit_o, 0);
        check("rst_err", target_err_o, 0);
        rtc_rst_n = 1'b1;

        // natural rollover, 8 ns steps, 100 ns pulse
        drive(0, 32'd999_999_976);
        drive(0, 32'd999_999_984);
        drive(0, 32'd999_999_992);
        for (int i = 0; i < 16; i++) drive(1, 32'(i * 8));
        check("t1_width", f_edge - r_edge, 13);
        check("t1_sec", pps_sec_o, 1);
        check("t1_cnt", pps_cnt_o, 1);

        // width clamp: zero and above NS_MAX both use the default
        pulse_width_i = 32'd0;
        drive(1, 32'd900_000_000);
        for (int i = 0; i < 7; i++) drive(2, 32'(i * 100_000_000));
        check("t2_w_zero", f_edge - r_edge, 5);
        pulse_width_i = 32'd1_200_000_000;
        for (int i = 0; i < 8; i++) drive(3, 32'(i * 100_000_000));
        check("t2_w_big", f_edge - r_edge, 5);

        // width NS_MAX: next rollover restarts a still-high pulse
        pulse_width_i = NS_MAX;
        drive(4, 32'd0);
        drive(4, 32'd999_999_998);
        drive(5, 32'd0);
        drive(5, 32'd1);
        check("t2_restart_cnt", pps_cnt_o, 5);
        pulse_width_i = 32'd100;
        drive(5, 32'd200);

        // seconds jumps are silent
        drive(9, 32'd0);
        drive(9, 32'd100);
        drive(3, 32'd0);
        drive(3, 32'd100);
        drive(0, 32'd0);
        drive(0, 32'd100);
        drive(0, 32'd200);
        check("t3_jump_cnt", pps_cnt_o, 5);
        drive(1, 32'd0);
        drive(1, 32'd50);
        drive(1, 32'd200);
        check("t3_after_cnt", pps_cnt_o, 6);
        check("t3_after_sec", pps_sec_o, 1);

        // disabled rollover, then enable mid-second
        pps_en_i = 1'b0;
        drive(1, 32'd300);
        drive(2, 32'd0);
        drive(2, 32'd100);
        pps_en_i = 1'b1;
        drive(2, 32'd500_000_000);
        drive(2, 32'd600_000_000);
        check("t3_en_cnt", pps_cnt_o, 6);
        drive(3, 32'd0);
        drive(3, 32'd100);
        drive(3, 32'd200);
        check("t3_en_next", pps_cnt_o, 7);

        // trigger: valid arm, hit once
        drive(9, 32'd0);
        drive(9, 32'd100);
        arm(10, 32'd500);
        drive(9, 32'd200);
        drive(9, 32'd999_999_000);
        drive(10, 32'd0);
        drive(10, 32'd400);
        drive(10, 32'd500);
        drive(10, 32'd600);
        drive(10, 32'd700);
        drive(10, 32'd800);
        check("t4_hits", n_hit, 1);
        arm(8, 32'd0);
        drive(10, 32'd900);
        arm(11, 32'd1_000_000_000);
        drive(10, 32'd1000);
        arm(10, 32'd1000);
        drive(10, 32'd1100);
        check("t4_errs", n_errev, 3);

        // arm, re-arm earlier, cancel: nothing fires
        arm(12, 32'd0);
        drive(10, 32'd2000);
        arm(11, 32'd5000);
        drive(10, 32'd3000);
        target_cancel_i = 1'b1;
        drive(10, 32'd4000);
        drive(11, 32'd0);
        drive(11, 32'd5000);
        drive(11, 32'd6000);
        drive(12, 32'd0);
        drive(12, 32'd100);
        drive(12, 32'd200);
        check("t5_no_hit", n_hit, 1);
        arm(12, 32'd300);
        drive(12, 32'd250);
        drive(12, 32'd300);
        target_cancel_i = 1'b1;
        drive(12, 32'd400);
        drive(12, 32'd500);
        check("t5_cancel_hit", n_hit, 1);
        arm(13, 32'd0);
        drive(12, 32'd600);
        drive(20, 32'd0);
        drive(20, 32'd100);
        check("t5_jump_hit", n_hit, 2);

        // async reset mid-pulse while armed
        arm(30, 32'd0);
        pulse_width_i = 32'd0;
        drive(20, 32'd200);
        drive(21, 32'd0);
        drive(21, 32'd100);
        drive(21, 32'd200);
        check("t6_pre_pps", pps_o, 1);
        check("t6_pre_pend", target_pend_o, 1);
        #3;
        rtc_rst_n = 1'b0;
        #1;
        check("t6_pps", pps_o, 0);
        check("t6_sec", pps_sec_o, 0);
        check("t6_cnt", pps_cnt_o, 0);
        check("t6_pend", target_pend_o, 0);
        check("t6_hit", target_hit_o, 0);
        check("t6_err", target_err_o, 0);
        check("t6_queue", q.size(), 0);
        q.delete();
        model_reset();
        @(posedge rtc_clk);
        @(posedge rtc_clk);
        #2;
        rtc_rst_n = 1'b1;
        pulse_width_i = 32'd100;
        drive(1, 32'd0);
        drive(1, 32'd100);
        drive(1, 32'd200);
        check("t6_first_roll", pps_cnt_o, 0);
        drive(2, 32'd0);
        drive(2, 32'd50);
        drive(2, 32'd200);
        check("t6_second_roll", pps_cnt_o, 1);
        drive(30, 32'd0);
        drive(30, 32'd100);
        drive(31, 32'd0);
        drive(31, 32'd100);
        check("t6_no_hit", n_hit, 2);

        check("leftover", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout edge %0d", edge_n);
        $fatal(1, "timeout");
    end

endmodule
